// File: rtl/ita_requant_pipe.sv
// Two-stage requantization pipeline: per-lane multiply, rounding right-shift, offset add, saturate.
// Optional saturation statistics counter is built when ITA_REQUANT_STATS_EN is defined.
module ita_requant_pipe #(
   parameter int N     = 16,
   parameter int ACC_W = 26,
   parameter int EMS   = 8,
   parameter int OUT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [N*ACC_W-1:0]   data_i,
   input  logic [EMS-1:0]       eps_mult_i,
   input  logic [EMS-1:0]       right_shift_i,
   input  logic [EMS-1:0]       add_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [N*OUT_W-1:0]   data_o,
   output logic [15:0]          sat_count_o,
   input  logic                 clear_i
);
   localparam int PW = ACC_W + EMS;
   localparam int GW = PW + 1;
   localparam int VW = GW + 1;
   localparam int CW = $clog2(N + 1);
   localparam logic [EMS-1:0]        SH_MAX = EMS'(PW - 1);
   localparam logic signed [VW-1:0]  SAT_HI = VW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
   localparam logic signed [VW-1:0]  SAT_LO = ~SAT_HI;

   // Returns {clamped, lane}; GW keeps one guard bit so the rounding add cannot overflow.
   function automatic logic [OUT_W:0] requant_lane(
      input logic signed [PW-1:0]  prod,
      input logic [EMS-1:0]        shift,
      input logic signed [EMS-1:0] add
   );
      logic [EMS-1:0]       sh;
      logic signed [GW-1:0] rnd;
      logic signed [GW-1:0] sum;
      logic signed [GW-1:0] r;
      logic signed [VW-1:0] v;
      logic [OUT_W:0]       res;
      sh = (shift > SH_MAX) ? SH_MAX : shift;
      if (sh != {EMS{1'b0}}) begin
         rnd = {{(GW-1){1'b0}}, 1'b1} << (sh - EMS'(1'b1));
      end else begin
         rnd = '0;
      end
      sum = GW'(prod) + rnd;
      r   = sum >>> sh;
      v   = VW'(r) + VW'(add);
      if (v > SAT_HI) begin
         res = {1'b1, SAT_HI[OUT_W-1:0]};
      end else if (v < SAT_LO) begin
         res = {1'b1, SAT_LO[OUT_W-1:0]};
      end else begin
         res = {1'b0, v[OUT_W-1:0]};
      end
      return res;
   endfunction

   logic                    s1_valid_r;
   logic signed [PW-1:0]    prod_s [N];
   logic signed [PW-1:0]    prod_r [N];
   logic [EMS-1:0]          shift_r;
   logic signed [EMS-1:0]   add_r;
   logic                    valid_r;
   logic [N*OUT_W-1:0]      data_r;
   logic [N*OUT_W-1:0]      lane_s;
   logic [OUT_W:0]          lane_res_s [N];
   logic [CW-1:0]           sat_lanes_s;
   logic                    s2_adv_s;
   logic                    s1_adv_s;

   assign s2_adv_s = !valid_r || ready_i;
   assign s1_adv_s = !s1_valid_r || s2_adv_s;
   assign ready_o  = s1_adv_s;
   assign valid_o  = valid_r;
   assign data_o   = data_r;

   // Full-precision signed lane products
   always_comb begin
      for (int i = 0; i < N; i++) begin
         prod_s[i] = PW'($signed(data_i[i*ACC_W +: ACC_W])) * PW'($signed(eps_mult_i));
      end
   end

   // Stage 1 register: products plus the beat's shift and offset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_r <= 1'b0;
         shift_r    <= '0;
         add_r      <= '0;
         for (int i = 0; i < N; i++) begin
            prod_r[i] <= '0;
         end
      end else if (s1_adv_s) begin
         s1_valid_r <= valid_i;
         if (valid_i) begin
            shift_r <= right_shift_i;
            add_r   <= $signed(add_i);
            for (int i = 0; i < N; i++) begin
               prod_r[i] <= prod_s[i];
            end
         end
      end
   end

   // Round, offset and clamp every lane; also count the lanes that clamped
   always_comb begin
      lane_s      = '0;
      sat_lanes_s = '0;
      for (int i = 0; i < N; i++) begin
         lane_res_s[i] = requant_lane(prod_r[i], shift_r, add_r);
         lane_s[i*OUT_W +: OUT_W] = lane_res_s[i][OUT_W-1:0];
         sat_lanes_s = sat_lanes_s + CW'(lane_res_s[i][OUT_W]);
      end
   end

   // Stage 2 register: output beat, held while downstream stalls
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_r <= 1'b0;
         data_r  <= '0;
      end else if (s2_adv_s) begin
         valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            data_r <= lane_s;
         end
      end
   end

`ifdef ITA_REQUANT_STATS_EN
   logic [CW-1:0] s2_sat_r;
   logic [15:0]   sat_cnt_r;
   logic [16:0]   sat_sum_s;

   assign sat_sum_s   = {1'b0, sat_cnt_r} + 17'(s2_sat_r);
   assign sat_count_o = sat_cnt_r;

   // Clamp count travels alongside the stage-2 beat
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_sat_r <= '0;
      end else if (s2_adv_s && s1_valid_r) begin
         s2_sat_r <= sat_lanes_s;
      end
   end

   // Saturating event counter; clear wins over a same-cycle increment
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sat_cnt_r <= 16'h0000;
      end else if (clear_i) begin
         sat_cnt_r <= 16'h0000;
      end else if (valid_r && ready_i) begin
         sat_cnt_r <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
      end
   end
`else
   logic unused_s;
   assign unused_s    = clear_i | (|sat_lanes_s);
   assign sat_count_o = 16'h0000;
`endif

endmodule
